// File: rtl/demux16_buf_pkg.sv
// demux16_buf_pkg
// Shared constants for the 16-channel buffered demultiplexer.
//   NUM_CH : number of output channels
//   SEL_W  : width of the channel select
package demux16_buf_pkg;
    localparam int NUM_CH = 16;
    localparam int SEL_W  = 4;
endpackage

// File: rtl/demux16_buf_slot.sv
// demux_slot
// One-deep output buffer for a single channel: a data register plus a
// valid flag.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   load      : write load_data this edge (already qualified by the top)
//   load_data : N-bit word to store
//   drain     : consumer takes the word this edge (ignored when empty)
//   data      : stored word
//   valid     : data holds an undelivered word
module demux_slot #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         drain,
    output logic [N-1:0] data,
    output logic         valid
);

    // A load wins over a drain: the old word leaves and the new word takes
    // its place in the same edge, so the flag stays set.  A drain alone
    // clears only the flag; the data register keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux16_buf.sv
// demux16_buf
// Demultiplexes a valid/ready write stream into 16 one-deep channel
// buffers, each drained independently by its own consumer.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in        : N-bit write data
//   s         : destination channel 0..15
//   in_valid  : write request valid
//   in_ready  : selected channel can accept this cycle (independent of in_valid)
//   out_0..15 : registered channel data
//   out_valid : bit k set when out_k holds an undelivered word
//   out_ready : bit k set when consumer k takes its word this cycle
//   count     : number of set out_valid bits, 0..16
module demux16_buf
    import demux16_buf_pkg::*;
#(
    parameter int N = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      in,
    input  logic [SEL_W-1:0]  s,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N-1:0]      out_0,
    output logic [N-1:0]      out_1,
    output logic [N-1:0]      out_2,
    output logic [N-1:0]      out_3,
    output logic [N-1:0]      out_4,
    output logic [N-1:0]      out_5,
    output logic [N-1:0]      out_6,
    output logic [N-1:0]      out_7,
    output logic [N-1:0]      out_8,
    output logic [N-1:0]      out_9,
    output logic [N-1:0]      out_10,
    output logic [N-1:0]      out_11,
    output logic [N-1:0]      out_12,
    output logic [N-1:0]      out_13,
    output logic [N-1:0]      out_14,
    output logic [N-1:0]      out_15,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [4:0]        count
);

    logic              load_en;
    logic [NUM_CH-1:0] load_vec;
    logic [NUM_CH-1:0] valid_vec;
    logic [N-1:0]      slot_data [NUM_CH];
    logic [4:0]        drain_cnt;
    logic              fill_empty;
    logic [4:0]        count_next;

    // A full channel accepts only when its consumer empties it this cycle.
    assign in_ready = ~valid_vec[s] | out_ready[s];
    assign load_en  = in_valid & in_ready;

    always_comb begin
        load_vec = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            load_vec[k] = load_en && (s == SEL_W'(k));
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_slot
            demux_slot #(.N(N)) u_slot (
                .clk       (clk),
                .rst       (rst),
                .load      (load_vec[g]),
                .load_data (in),
                .drain     (out_ready[g]),
                .data      (slot_data[g]),
                .valid     (valid_vec[g])
            );
        end
    endgenerate

    // Count tracks the flags exactly: a drain that coincides with a load on
    // the same channel is a replacement and does not change occupancy.
    always_comb begin
        drain_cnt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (valid_vec[k] && out_ready[k] && !load_vec[k]) begin
                drain_cnt = drain_cnt + 5'd1;
            end
        end
        fill_empty = load_en & ~valid_vec[s];
        count_next = count + {4'b0000, fill_empty} - drain_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign out_valid = valid_vec;
    assign out_0  = slot_data[0];
    assign out_1  = slot_data[1];
    assign out_2  = slot_data[2];
    assign out_3  = slot_data[3];
    assign out_4  = slot_data[4];
    assign out_5  = slot_data[5];
    assign out_6  = slot_data[6];
    assign out_7  = slot_data[7];
    assign out_8  = slot_data[8];
    assign out_9  = slot_data[9];
    assign out_10 = slot_data[10];
    assign out_11 = slot_data[11];
    assign out_12 = slot_data[12];
    assign out_13 = slot_data[13];
    assign out_14 = slot_data[14];
    assign out_15 = slot_data[15];

endmodule

// File: tb/tb_demux16_buf.sv
// tb_demux16_buf
// Self-checking bench for demux16_buf (N=32). Accepted words are pushed
// into a per-channel scoreboard queue and popped when the consumer takes
// them; flags, count and in_ready are checked against a reference model.
module tb_demux16_buf;

    logic        clk;
    logic        rst;
    logic [31:0] in;
    logic [3:0]  s;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7;
    logic [31:0] out_8, out_9, out_10, out_11, out_12, out_13, out_14, out_15;
    logic [15:0] out_valid;
    logic [15:0] out_ready;
    logic [4:0]  count;

    demux16_buf #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .s         (s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_0     (out_0),
        .out_1     (out_1),
        .out_2     (out_2),
        .out_3     (out_3),
        .out_4     (out_4),
        .out_5     (out_5),
        .out_6     (out_6),
        .out_7     (out_7),
        .out_8     (out_8),
        .out_9     (out_9),
        .out_10    (out_10),
        .out_11    (out_11),
        .out_12    (out_12),
        .out_13    (out_13),
        .out_14    (out_14),
        .out_15    (out_15),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] out_arr [16];
    always_comb begin
        out_arr[0]  = out_0;   out_arr[1]  = out_1;   out_arr[2]  = out_2;   out_arr[3]  = out_3;
        out_arr[4]  = out_4;   out_arr[5]  = out_5;   out_arr[6]  = out_6;   out_arr[7]  = out_7;
        out_arr[8]  = out_8;   out_arr[9]  = out_9;   out_arr[10] = out_10;  out_arr[11] = out_11;
        out_arr[12] = out_12;  out_arr[13] = out_13;  out_arr[14] = out_14;  out_arr[15] = out_15;
    end

    int errors = 0;
    int checks = 0;

    // reference model and scoreboard
    logic [15:0] m_valid;
    logic [31:0] m_data [16];
    int          m_count;
    logic [31:0] sb_q [16][$];
    logic [31:0] dlv_exp [$];
    logic [31:0] dlv_act [$];
    logic        ready_seen;
    logic        ready_exp;

    function automatic int popc(input logic [15:0] v);
        int c = 0;
        for (int i = 0; i < 16; i++) if (v[i]) c++;
        return c;
    endfunction

    task automatic model_clear();
        m_valid = '0;
        m_count = 0;
        for (int k = 0; k < 16; k++) begin
            m_data[k] = '0;
            sb_q[k].delete();
        end
        dlv_exp.delete();
        dlv_act.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = '0; s = '0; in = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    // One clock of stimulus: the model updates and the scoreboard collects
    // expected/actual pairs for every word handed to a consumer.
    task automatic tick(input logic [3:0] ss, input logic [31:0] din,
                        input logic iv, input logic [15:0] ordy);
        logic acc;
        s = ss; in = din; in_valid = iv; out_ready = ordy;
        #1;
        ready_seen = in_ready;
        ready_exp  = !m_valid[ss] || ordy[ss];
        acc = iv && ready_exp;
        for (int k = 0; k < 16; k++) begin
            if (m_valid[k] && ordy[k]) begin
                if (sb_q[k].size() > 0) begin
                    dlv_exp.push_back(sb_q[k].pop_front());
                    dlv_act.push_back(out_arr[k]);
                end
                m_valid[k] = 1'b0;
                m_count--;
            end
        end
        if (acc) begin
            m_valid[ss] = 1'b1;
            m_data[ss]  = din;
            m_count++;
            sb_q[ss].push_back(din);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; s = 4'd3; in = 32'h1234_5678; out_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = '0;
        model_clear();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 16'h0000) begin errors++; $display("FAIL reset_out_valid got=%h exp=0000", out_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (out_3 !== 32'h0) begin errors++; $display("FAIL reset_out_3 got=%h exp=0", out_3); end
    endtask

    task automatic test_single_load();
        do_reset();
        tick(4'd3, 32'hDEAD_BEEF, 1'b1, 16'h0000);
        in_valid = 1'b0;
        checks++; if (out_3 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_out_3 got=%h exp=deadbeef", out_3); end
        checks++; if (out_valid !== 16'h0008) begin errors++; $display("FAIL load_out_valid got=%h exp=0008", out_valid); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL load_count got=%0d exp=1", count); end
    endtask

    task automatic test_full_block();
        do_reset();
        tick(4'd5, 32'h0000_00AA, 1'b1, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick(4'd5, 32'h0000_0001, 1'b1, 16'h0000);
            checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL full_in_ready cyc=%0d got=%b exp=0", i, ready_seen); end
            checks++; if (out_5 !== 32'hAA) begin errors++; $display("FAIL full_out_5 cyc=%0d got=%h exp=aa", i, out_5); end
            checks++; if (count !== 5'd1) begin errors++; $display("FAIL full_count cyc=%0d got=%0d exp=1", i, count); end
        end
    endtask

    // relies on channel 5 holding 0xAA from test_full_block
    task automatic test_replace();
        tick(4'd5, 32'h0000_00BB, 1'b1, 16'h0020);
        in_valid = 1'b0; out_ready = '0;
        checks++; if (ready_seen !== 1'b1) begin errors++; $display("FAIL replace_in_ready got=%b exp=1", ready_seen); end
        checks++; if (out_5 !== 32'hBB) begin errors++; $display("FAIL replace_out_5 got=%h exp=bb", out_5); end
        checks++; if (out_valid[5] !== 1'b1) begin errors++; $display("FAIL replace_valid5 got=%b exp=1", out_valid[5]); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL replace_count got=%0d exp=1", count); end
        checks++;
        if (dlv_exp.size() != 1) begin
            errors++; $display("FAIL replace_delivered got=%0d words exp=1", dlv_exp.size());
        end else if (dlv_act[0] !== 32'hAA) begin
            errors++; $display("FAIL replace_delivered got=%h exp=aa", dlv_act[0]);
        end
        dlv_exp.delete(); dlv_act.delete();
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int k = 0; k < 16; k++) tick(4'(k), 32'(k), 1'b1, 16'h0000);
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count got=%0d exp=16", count); end
        s = 4'd7; in_valid = 1'b1; out_ready = '0; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b exp=0", in_ready); end
        tick(4'd7, 32'h0000_0077, 1'b1, 16'h8081);
        in_valid = 1'b0; out_ready = '0;
        checks++; if (count !== 5'd14) begin errors++; $display("FAIL drain_count got=%0d exp=14", count); end
        checks++; if (out_7 !== 32'h77) begin errors++; $display("FAIL drain_out_7 got=%h exp=77", out_7); end
        checks++; if (out_valid !== 16'h7FFE) begin errors++; $display("FAIL drain_out_valid got=%h exp=7ffe", out_valid); end
        checks++; if (out_15 !== 32'd15) begin errors++; $display("FAIL drain_out_15_hold got=%h exp=f", out_15); end
        for (int i = 0; i < dlv_exp.size(); i++) begin
            checks++; if (dlv_act[i] !== dlv_exp[i]) begin errors++; $display("FAIL drain_word got=%h exp=%h", dlv_act[i], dlv_exp[i]); end
        end
        dlv_exp.delete(); dlv_act.delete();
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(4'd2, 32'h0000_0022, 1'b1, 16'h0000);
        tick(4'd9, 32'h0000_0099, 1'b1, 16'h0000);
        rst = 1'b1; in_valid = 1'b1; s = 4'd4; in = 32'h0000_0044; out_ready = '0;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; s = 4'd2;
        model_clear();
        #1;
        checks++; if (out_valid !== 16'h0000) begin errors++; $display("FAIL rstmid_out_valid got=%h exp=0000", out_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", count); end
        checks++; if (out_4 !== 32'h0) begin errors++; $display("FAIL rstmid_out_4 got=%h exp=0", out_4); end
        checks++; if (out_2 !== 32'h0) begin errors++; $display("FAIL rstmid_out_2 got=%h exp=0", out_2); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_random();
        logic [15:0] ordy;
        int err_start;
        do_reset();
        err_start = errors;
        for (int c = 0; c < 10000; c++) begin
            ordy = '0;
            for (int k = 0; k < 16; k++) ordy[k] = ($urandom_range(0, 99) < 25);
            tick(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0), ordy);
            if (errors - err_start > 20) continue;
            checks++; if (ready_seen !== ready_exp) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, ready_seen, ready_exp); end
            checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%h exp=%h", c, out_valid, m_valid); end
            checks++; if (int'(count) != m_count || int'(count) != popc(out_valid)) begin
                errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d pop=%0d", c, count, m_count, popc(out_valid));
            end
            while (dlv_exp.size() > 0) begin
                logic [31:0] e, a;
                e = dlv_exp.pop_front();
                a = dlv_act.pop_front();
                checks++; if (a !== e) begin errors++; $display("FAIL rnd_word cyc=%0d got=%h exp=%h", c, a, e); end
            end
            for (int k = 0; k < 16; k++) begin
                if (m_valid[k]) begin
                    checks++; if (out_arr[k] !== m_data[k]) begin errors++; $display("FAIL rnd_data ch=%0d cyc=%0d got=%h exp=%h", k, c, out_arr[k], m_data[k]); end
                end
            end
        end
        dlv_exp.delete(); dlv_act.delete();
    endtask

    initial begin
        rst = 1'b1; in = '0; s = '0; in_valid = 1'b0; out_ready = '0;
        model_clear();
        test_reset();
        test_single_load();
        test_full_block();
        test_replace();
        test_fill_drain();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux16_buf.md
DEMUX16_BUF -- requirements
Module: demux16_buf

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the data width of the input and of each output channel.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in, input, N bits: write data.
REQ-005 The block SHALL have port s, input, 4 bits: destination channel select, 0..15.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the write request is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the selected channel can accept data this cycle.
REQ-008 The block SHALL have ports out_0 .. out_15, each output, N bits: registered channel data.
REQ-009 The block SHALL have port out_valid, output, 16 bits: bit k marks out_k as holding undelivered data.
REQ-010 The block SHALL have port out_ready, input, 16 bits: bit k means the consumer of channel k takes data this cycle.
REQ-011 The block SHALL have port count, output, 5 bits: number of set out_valid bits, 0..16.

Function
REQ-012 Each channel k SHALL be a one-deep buffer made of data register out_k and flag out_valid[k].
REQ-013 in_ready SHALL be combinational: NOT out_valid[s] OR out_ready[s]; it SHALL NOT depend on in_valid.
REQ-014 Load: when in_valid AND in_ready, the block SHALL on the next edge set out_k to in and set out_valid[k] to 1, where k = s.
REQ-015 Drain: when out_valid[k] AND out_ready[k] with no load into k, out_valid[k] SHALL clear on the next edge; out_k SHALL hold its value.
REQ-016 Simultaneous drain and load on the same channel SHALL replace the data, leave out_valid[k] at 1, and lose or duplicate no word.
REQ-017 The block SHALL ignore out_ready[k] while out_valid[k] is 0.
REQ-018 Independent drains on any subset of channels SHALL complete in the same cycle as a load into a different channel.
REQ-019 Load latency SHALL be 1 cycle: data written at edge t appears on out_k with out_valid[k]=1 after edge t.
REQ-020 A load attempt into a full channel that is not draining SHALL leave that channel unchanged; in_ready=0 signals this to the producer, who must hold the request.
REQ-021 count SHALL be a register updated with the flags: +1 for a load into an empty channel, -1 for each drain with no load into the same channel, otherwise unchanged; count SHALL always equal popcount(out_valid).
REQ-022 When count=16, a load SHALL succeed only on a channel that drains in the same cycle; count SHALL NOT exceed 16 or wrap.

Reset
REQ-023 While rst=1 at an edge, all out_valid bits, all out_k and count SHALL be set to 0, overriding any load or drain in that cycle.
REQ-024 Reset mid-operation SHALL discard all buffered words; in_ready SHALL read 1 in the first cycle after reset.

Structure
REQ-025 A shared package SHALL hold localparams NUM_CH=16 and SEL_W=4; no typedefs are needed.
REQ-026 One sub-module, demux_slot (parameter N; ports clk, rst, load, load_data, drain, data, valid), SHALL implement a single channel and be instantiated 16 times.
REQ-027 The top level SHALL contain only the 4-to-16 load decode, the in_ready mux, and the count register.

Verification
REQ-028 Reset, then s=3, in=0xDEADBEEF, in_valid=1 for one cycle -> out_3=0xDEADBEEF, out_valid=0x0008, count=1 on the next cycle.
REQ-029 Channel 5 full, out_ready[5]=0, in_valid=1, s=5, in=0x1 -> in_ready=0; out_5 and count unchanged for 3 cycles.
REQ-030 Channel 5 full with 0xAA, out_ready[5]=1, load s=5, in=0xBB in the same cycle -> out_5=0xBB, out_valid[5]=1, count unchanged.
REQ-031 Load all 16 channels with value k -> count=16; drain channels 0 and 15 while loading channel 7 (also draining) -> count=14, out_7 holds the new data.
REQ-032 Channels 2 and 9 full, assert rst while in_valid=1 with s=4 -> next cycle out_valid=0, count=0, out_4=0.
REQ-033 Randomized 10k cycles against a 16-slot scoreboard -> no lost or duplicated word, and count equals popcount(out_valid) every cycle.
